// File: rtl/stack_pkg.sv
// Shared types for the stack-pointer controller: op codes, fault codes, FSM states.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_PUSH  = 3'b001,
        OP_POP   = 3'b010,
        OP_BINOP = 3'b011,
        OP_POP2  = 3'b100,
        OP_CLR   = 3'b101
    } op_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UDF  = 2'b10;

endpackage

// File: rtl/stack_bounds_check.sv
// Combinational legality check of one stack op against the current depth.
// Only instantiated when STACK_BOUNDS_CHECK_EN is defined.
module stack_bounds_check
    import stack_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
    input  op_t                op,
    input  logic [DEPTH_W-1:0] depth_q,
    output logic               legal,
    output logic [1:0]         code
);

    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(DEPTH);

    always_comb begin
        legal = 1'b1;
        code  = FC_NONE;
        case (op)
            OP_PUSH: if (depth_q == DEPTH_FULL) begin
                legal = 1'b0;
                code  = FC_OVF;
            end
            OP_POP: if (depth_q == '0) begin
                legal = 1'b0;
                code  = FC_UDF;
            end
            OP_BINOP, OP_POP2: if (depth_q < DEPTH_W'(2)) begin
                legal = 1'b0;
                code  = FC_UDF;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stack_pointer_ctrl.sv
// Stack-pointer controller feeding the stack memory's SP/StackWrite in the same cycle.
// Optional bounds checking and sticky FAULT state enabled by STACK_BOUNDS_CHECK_EN.
module stack_pointer_ctrl
    import stack_pkg::*;
#(
    parameter int REG_BITS = 32,
    parameter int DEPTH    = 64,
    parameter int DEPTH_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    // Handshake: an op fires on a cycle where op_valid && op_ready; op_ready
    // depends on op itself (CLR is always accepted) and never on op_valid.
    input  logic                op_valid,
    input  logic [2:0]          op,
    output logic                op_ready,
    output logic [REG_BITS-1:0] sp,
    output logic                stack_write,
    output logic [DEPTH_W-1:0]  depth,
    output logic                empty,
    output logic                full,
    output logic                fault,
    output logic [1:0]          fault_code,
    output state_t              dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]   IDX_TOP    = IDX_W'(DEPTH - 1);
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(DEPTH);

    logic [IDX_W-1:0]   r_sp, w_sp_next;
    logic [DEPTH_W-1:0] r_depth, w_depth_next;
    logic               w_fire, w_we, w_legal;
    op_t                w_op;

    assign w_op   = op_t'(op);
    assign w_fire = op_valid && op_ready;

`ifdef STACK_BOUNDS_CHECK_EN
    state_t     r_state, w_state_next;
    logic [1:0] r_code, w_code_next, w_chk_code;

    stack_bounds_check #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_bounds_check (
        .op      (w_op),
        .depth_q (r_depth),
        .legal   (w_legal),
        .code    (w_chk_code)
    );

    assign op_ready = (r_state == ST_RUN) || (w_op == OP_CLR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_code  <= FC_NONE;
        end else begin
            r_state <= w_state_next;
            r_code  <= w_code_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_code;
        if (w_fire) begin
            if (w_op == OP_CLR) begin
                w_state_next = ST_RUN;
                w_code_next  = FC_NONE;
            end else if (!w_legal) begin
                w_state_next = ST_FAULT;
                w_code_next  = w_chk_code;
            end
        end
    end

    assign fault      = (r_state == ST_FAULT);
    assign fault_code = r_code;
    assign dbg_state  = r_state;
`else
    assign w_legal    = 1'b1;
    assign op_ready   = 1'b1;
    assign fault      = 1'b0;
    assign fault_code = FC_NONE;
    assign dbg_state  = ST_RUN;
`endif

    // Depth saturation only matters when unchecked; checked builds never reach it.
    always_comb begin
        w_sp_next    = r_sp;
        w_depth_next = r_depth;
        w_we         = 1'b0;
        if (w_fire) begin
            if (w_op == OP_CLR) begin
                w_sp_next    = IDX_TOP;
                w_depth_next = '0;
            end else if (w_legal) begin
                case (w_op)
                    OP_PUSH: begin
                        w_sp_next    = r_sp + 1'b1;
                        w_depth_next = (r_depth == DEPTH_FULL) ? r_depth : r_depth + 1'b1;
                        w_we         = 1'b1;
                    end
                    OP_POP: begin
                        w_sp_next    = r_sp - 1'b1;
                        w_depth_next = (r_depth == '0) ? r_depth : r_depth - 1'b1;
                    end
                    OP_BINOP: begin
                        w_sp_next    = r_sp - 1'b1;
                        w_depth_next = (r_depth == '0) ? r_depth : r_depth - 1'b1;
                        w_we         = 1'b1;
                    end
                    OP_POP2: begin
                        w_sp_next    = r_sp - 2'd2;
                        w_depth_next = (r_depth < DEPTH_W'(2)) ? '0 : r_depth - 2'd2;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp    <= IDX_TOP;
            r_depth <= '0;
        end else begin
            r_sp    <= w_sp_next;
            r_depth <= w_depth_next;
        end
    end

    assign sp          = {{(REG_BITS - IDX_W){1'b0}}, w_sp_next};
    assign stack_write = w_we;
    assign depth       = r_depth;
    assign empty       = (r_depth == '0);
    assign full        = (r_depth == DEPTH_FULL);

endmodule

// File: tb/tb_stack_pointer_ctrl.sv
// Directed bench for stack_pointer_ctrl; covers both STACK_BOUNDS_CHECK_EN builds.
module tb_stack_pointer_ctrl;
    import stack_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic        op_ready;
    logic [31:0] sp;
    logic        stack_write;
    logic [6:0]  depth;
    logic        empty, full, fault;
    logic [1:0]  fault_code;
    state_t      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    stack_pointer_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op          (op),
        .op_ready    (op_ready),
        .sp          (sp),
        .stack_write (stack_write),
        .depth       (depth),
        .empty       (empty),
        .full        (full),
        .fault       (fault),
        .fault_code  (fault_code),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present an op mid-cycle; combinational outputs are checked before the next rising edge.
    task automatic drive(input logic v, input logic [2:0] o);
        @(negedge clk);
        op_valid = v;
        op       = o;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, OP_NOP);
    endtask

    initial begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op       = OP_NOP;
        #12;
        chk("rst_sp", sp, 63);
        chk("rst_depth", depth, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_fault", fault, 0);
        chk("rst_we", stack_write, 0);
        chk("rst_ready", op_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Three pushes, binop, pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_PUSH);
            chk("push3_sp", sp, i);
            chk("push3_we", stack_write, 1);
        end
        drive(1'b1, OP_BINOP);
        chk("binop_sp", sp, 1);
        chk("binop_we", stack_write, 1);
        drive(1'b1, OP_POP);
        chk("pop_sp", sp, 0);
        chk("pop_we", stack_write, 0);
        idle();
        chk("seq_depth", depth, 1);
        chk("seq_idle_sp", sp, 0);

        // Undefined op code acts as NOP; POP at index 0 wraps to 63
        drive(1'b1, 3'b110);
        chk("op110_sp", sp, 0);
        chk("op110_we", stack_write, 0);
        drive(1'b1, OP_POP);
        chk("pop_wrap_sp", sp, 63);
        idle();
        chk("pop_wrap_empty", empty, 1);

        // Three pushes then POP2
        for (int i = 0; i < 3; i++) drive(1'b1, OP_PUSH);
        drive(1'b1, OP_POP2);
        chk("pop2_sp", sp, 0);
        chk("pop2_we", stack_write, 0);
        idle();
        chk("pop2_depth", depth, 1);
        drive(1'b1, OP_CLR);
        chk("clr_sp", sp, 63);
        idle();
        chk("clr_depth", depth, 0);

        // Fill to 64
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, OP_PUSH);
            chk("fill_sp", sp, i);
        end
        idle();
        chk("fill_full", full, 1);
        chk("fill_depth", depth, 64);

`ifdef STACK_BOUNDS_CHECK_EN
        drive(1'b1, OP_PUSH);
        chk("ovf_we", stack_write, 0);
        chk("ovf_sp", sp, 63);
        drive(1'b0, OP_PUSH);
        chk("ovf_fault", fault, 1);
        chk("ovf_code", fault_code, 1);
        chk("ovf_ready_push", op_ready, 0);
        chk("ovf_state", dbg_state, ST_FAULT);
        chk("ovf_depth", depth, 64);
        drive(1'b0, OP_CLR);
        chk("ovf_ready_clr", op_ready, 1);
        drive(1'b1, OP_CLR);
        idle();
        chk("ovf_clr_fault", fault, 0);
        chk("ovf_clr_depth", depth, 0);

        // Underflow from empty
        drive(1'b1, OP_POP);
        chk("udf_sp", sp, 63);
        chk("udf_we", stack_write, 0);
        idle();
        chk("udf_code", fault_code, 2);
        chk("udf_depth", depth, 0);
        drive(1'b1, OP_PUSH);
        chk("udf_push_ready", op_ready, 0);
        chk("udf_push_we", stack_write, 0);
        chk("udf_push_sp", sp, 63);
        idle();
        chk("udf_push_depth", depth, 0);
        drive(1'b1, OP_CLR);
        drive(1'b0, OP_NOP);
        chk("udf_clr_fault", fault, 0);
        chk("udf_clr_ready", op_ready, 1);
        chk("udf_clr_code", fault_code, 0);

        // BINOP with depth 1
        drive(1'b1, OP_PUSH);
        drive(1'b1, OP_BINOP);
        chk("binop_udf_sp", sp, 0);
        chk("binop_udf_we", stack_write, 0);
        idle();
        chk("binop_udf_code", fault_code, 2);
        chk("binop_udf_depth", depth, 1);
`else
        drive(1'b1, OP_PUSH);
        chk("wrap_sp", sp, 0);
        chk("wrap_we", stack_write, 1);
        idle();
        chk("wrap_depth", depth, 64);
        chk("wrap_fault", fault, 0);
        chk("wrap_ready", op_ready, 1);
        drive(1'b1, OP_CLR);
        drive(1'b1, OP_POP);
        chk("nochk_pop_sp", sp, 62);
        idle();
        chk("nochk_pop_depth", depth, 0);
        chk("nochk_pop_fault", fault_code, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_pointer_ctrl.md
# stack_pointer_ctrl

- Stack-pointer controller: the stage directly upstream of the 64-entry stack memory.
- Accepts one decoded stack operation per cycle from instruction decode.
- Maintains the top-of-stack index and depth, and drives the memory's `SP` and `StackWrite` inputs.
- Detects overflow and underflow; a detected error parks the controller in a sticky fault state.

## Interface
- `REG_BITS`, 32, width of `sp`; matches the stack memory word/address width.
- `DEPTH`, 64, number of stack entries; power of two, at most 2^REG_BITS.
- `DEPTH_W`, `$clog2(DEPTH+1)`, width of `depth` (derived; not overridden).
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `op_valid`  in  1  an operation is presented.
- `op`  in  3  operation code: NOP=000, PUSH=001, POP=010, BINOP=011 (pop two, push one), POP2=100, CLR=101; 110/111 are treated as NOP.
- `op_ready`  out  1  controller accepts `op` this cycle.
- `sp`  out  REG_BITS  stack memory address (the memory's `SP`).
- `stack_write`  out  1  stack memory write enable (the memory's `StackWrite`).
- `depth`  out  DEPTH_W  number of valid entries.
- `empty`  out  1  `depth == 0`.
- `full`  out  1  `depth == DEPTH`.
- `fault`  out  1  controller is in FAULT.
- `fault_code`  out  2  01 = overflow, 10 = underflow, 00 = none.

## Operation
- Registered state:
  - `sp_q` holds the index of the top entry. Empty is encoded as `sp_q = DEPTH-1`, so the first push lands at index 0.
  - `depth_q`, `state` (RUN/FAULT), `fault_code_q`.
- Index arithmetic: all index arithmetic is modulo DEPTH. `sp` is zero-extended to REG_BITS.
- An op fires when `op_valid && op_ready`. `op_ready = (state == RUN) || (op == CLR)`.
- `sp` is combinational and always equals the next top index. With `sp_next = sp_q` when nothing fires:

  | Fired op | `sp_next` | `depth` change | `stack_write` | Legal when |
  |---|---|---|---|---|
  | PUSH | `sp_q + 1` | +1 | 1 | `depth_q < DEPTH` |
  | POP | `sp_q - 1` | -1 | 0 | `depth_q >= 1` |
  | BINOP | `sp_q - 1` | -1 | 1 (result overwrites new top) | `depth_q >= 2` |
  | POP2 | `sp_q - 2` | -2 | 0 | `depth_q >= 2` |
  | CLR | `DEPTH-1` | depth 0 | 0 | always |

  - CLR also sets state RUN and `fault_code` to 00.
- Illegal op:
  - `sp_q` and `depth_q` are unchanged.
  - `stack_write = 0`; `sp = sp_q`.
  - State goes to FAULT and `fault_code` latches 01 (overflow) or 10 (underflow).
- State machine:
  - RUN → FAULT on an illegal fired op.
  - FAULT → RUN only on CLR.
  - In FAULT, every op other than CLR is not ready and has no effect.
- `stack_write` is 1 only for a fired, legal PUSH or BINOP.

## Timing
- Reset (async assert, sync deassert by the system) sets:
  - `sp_q = DEPTH-1`, `depth = 0`, state RUN, `fault_code = 00`.
  - Outputs during reset: `empty = 1`, `full = 0`, `fault = 0`, `stack_write = 0`, `sp = DEPTH-1`, `op_ready = 1`.
- Zero-cycle decision: `sp` and `stack_write` are valid in the same cycle `op` is presented. The memory samples them at that edge.
- Registers update on that same edge. `depth`, `empty`, `full` and `fault` reflect the op from the next cycle onward.
- Back-to-back ops every cycle are supported.
- Wrap-around: PUSH at `sp_q = DEPTH-1` with `depth < DEPTH` gives `sp = 0`. POP at `sp_q = 0` gives `sp = DEPTH-1`.
- Reset asserted mid-sequence: state returns to reset values immediately. A write already in progress in that cycle is not guaranteed.

## Configuration
- `STACK_BOUNDS_CHECK_EN` defined:
  - Legality checks, the FAULT state and `fault_code` behave as described above.
- `STACK_BOUNDS_CHECK_EN` undefined:
  - Every op is legal; `sp` wraps modulo DEPTH silently.
  - `depth` saturates at 0 and DEPTH.
  - `op_ready` is tied to 1; `fault` and `fault_code` are tied to 0; there is no FAULT state.

## Structure
- Shared package `stack_pkg` holds:
  - the op enum (3-bit),
  - the fault code constants,
  - the state enum (RUN/FAULT).
- One sub-module, `stack_bounds_check`. It is combinational: it takes `op` and `depth_q` and returns `legal` and `code`. It is instantiated only under `STACK_BOUNDS_CHECK_EN`.

## Test plan
- Reset, then idle:
  - `sp = 63`, `depth = 0`, `empty = 1`, `stack_write = 0`, `fault = 0`.
- Three PUSHes, then BINOP, then POP:
  - `sp` reads 0, 1, 2 with `stack_write = 1`.
  - Then BINOP gives `sp = 1` with `stack_write = 1`.
  - Then POP gives `sp = 0`.
  - Final `depth = 1`.
- 64 PUSHes, then a 65th:
  - `full = 1` after the 64th.
  - The 65th gives `stack_write = 0` and `sp = 63`.
  - Next cycle: `fault = 1`, `fault_code = 01`, `op_ready = 0` for PUSH.
- From reset, one POP:
  - `fault_code = 10`, `depth` stays 0.
  - A subsequent PUSH is ignored.
  - CLR then returns `fault = 0` and `op_ready = 1`.
- One PUSH, then BINOP (`depth = 1`):
  - Underflow fault; `sp` stays 0.
- With `STACK_BOUNDS_CHECK_EN` undefined, 65 PUSHes:
  - The 65th writes at `sp = 0` (wrap).
  - `depth` stays 64; `fault` stays 0.
